// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, counter sizing helper and lock-state encoding
// for the VGA output stage.
package vga_timing_pkg;

  localparam int VGA_TOTAL_COLS    = 800;
  localparam int VGA_TOTAL_ROWS    = 525;
  localparam int VGA_ACTIVE_COLS   = 640;
  localparam int VGA_ACTIVE_ROWS   = 480;
  localparam int VGA_H_FRONT_PORCH = 16;
  localparam int VGA_H_BACK_PORCH  = 48;
  localparam int VGA_V_FRONT_PORCH = 10;
  localparam int VGA_V_BACK_PORCH  = 33;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // Bits needed to count 0..total-1 (at least one bit).
  function automatic int cnt_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/porch_frame_count.sv
// Frame-start detection and column/row position counters; flags a frame start that
// arrives anywhere other than right after the last pixel of a frame.
module porch_frame_count #(
  parameter int TOTAL_COLS = 800,
  parameter int TOTAL_ROWS = 525,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_vsync,
  input  logic             vsync_d,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             fs,
  output logic             fs_unexpected
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(TOTAL_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TOTAL_ROWS - 1);

  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;
  logic             at_last;

  assign fs            = i_vsync & ~vsync_d;
  assign at_last       = (col_reg == COL_LAST) && (row_reg == ROW_LAST);
  assign fs_unexpected = fs & ~at_last;

  // A frame start re-anchors the counters onto the pixel being captured this edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (fs) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (col_reg == COL_LAST) begin
      col_reg <= '0;
      row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + ROW_W'(1);
    end else begin
      col_reg <= col_reg + COL_W'(1);
    end
  end

  assign col = col_reg;
  assign row = row_reg;

endmodule

// File: rtl/vga_sync_porch.sv
// VGA output stage: regenerates negative-polarity hsync/vsync with porches from the
// upstream active flags, blanks video outside the visible area and reports lock/resync.
module vga_sync_porch
  import vga_timing_pkg::*;
#(
  parameter int VIDEO_WIDTH   = 3,
  parameter int TOTAL_COLS    = VGA_TOTAL_COLS,
  parameter int TOTAL_ROWS    = VGA_TOTAL_ROWS,
  parameter int ACTIVE_COLS   = VGA_ACTIVE_COLS,
  parameter int ACTIVE_ROWS   = VGA_ACTIVE_ROWS,
  parameter int H_FRONT_PORCH = VGA_H_FRONT_PORCH,
  parameter int H_BACK_PORCH  = VGA_H_BACK_PORCH,
  parameter int V_FRONT_PORCH = VGA_V_FRONT_PORCH,
  parameter int V_BACK_PORCH  = VGA_V_BACK_PORCH
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_hsync,
  input  logic                   i_vsync,
  input  logic [VIDEO_WIDTH-1:0] i_red_video,
  input  logic [VIDEO_WIDTH-1:0] i_green_video,
  input  logic [VIDEO_WIDTH-1:0] i_blue_video,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic [VIDEO_WIDTH-1:0] o_red_video,
  output logic [VIDEO_WIDTH-1:0] o_green_video,
  output logic [VIDEO_WIDTH-1:0] o_blue_video,
  output logic                   o_locked,
  output logic                   o_resync_err
);

  localparam int COL_W = cnt_width(TOTAL_COLS);
  localparam int ROW_W = cnt_width(TOTAL_ROWS);

  localparam logic [COL_W-1:0] H_START = COL_W'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [COL_W-1:0] H_END   = COL_W'(TOTAL_COLS - H_BACK_PORCH - 1);
  localparam logic [ROW_W-1:0] V_START = ROW_W'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [ROW_W-1:0] V_END   = ROW_W'(TOTAL_ROWS - V_BACK_PORCH - 1);
  localparam logic [COL_W-1:0] H_ACT   = COL_W'(ACTIVE_COLS);
  localparam logic [ROW_W-1:0] V_ACT   = ROW_W'(ACTIVE_ROWS);

  if (TOTAL_COLS - H_BACK_PORCH - ACTIVE_COLS - H_FRONT_PORCH < 1) begin : g_bad_h
    $error("vga_sync_porch: horizontal porches leave no hsync pulse");
  end
  if (TOTAL_ROWS - V_BACK_PORCH - ACTIVE_ROWS - V_FRONT_PORCH < 1) begin : g_bad_v
    $error("vga_sync_porch: vertical porches leave no vsync pulse");
  end

  // Stage 1: raw capture of the upstream pixel.
  logic                   vsync_d;
  logic                   hsync_d;
  logic [VIDEO_WIDTH-1:0] red_d, green_d, blue_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vsync_d <= 1'b0;
      hsync_d <= 1'b0;
      red_d   <= '0;
      green_d <= '0;
      blue_d  <= '0;
    end else begin
      vsync_d <= i_vsync;
      hsync_d <= i_hsync;
      red_d   <= i_red_video;
      green_d <= i_green_video;
      blue_d  <= i_blue_video;
    end
  end

  // Horizontal position comes from the counters; the captured hsync is kept only for alignment.
  logic unused_hsync;
  assign unused_hsync = hsync_d;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             fs;
  logic             fs_unexpected;

  porch_frame_count #(
    .TOTAL_COLS(TOTAL_COLS),
    .TOTAL_ROWS(TOTAL_ROWS),
    .COL_W     (COL_W),
    .ROW_W     (ROW_W)
  ) u_frame_count (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_vsync      (i_vsync),
    .vsync_d      (vsync_d),
    .col          (col),
    .row          (row),
    .fs           (fs),
    .fs_unexpected(fs_unexpected)
  );

  lock_state_t state_reg, state_next;
  logic        err_pend_reg, err_pend_next;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg    <= UNLOCKED;
      err_pend_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      err_pend_reg <= err_pend_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    err_pend_next = 1'b0;
    case (state_reg)
      UNLOCKED: if (fs) state_next = LOCKED;
      LOCKED:   err_pend_next = fs_unexpected;
      default:  state_next = UNLOCKED;
    endcase
  end

  // Stage 2: sync/blanking decode of the stage-1 pixel at (col,row).
  logic                   hsync_next, vsync_next, locked_next;
  logic [VIDEO_WIDTH-1:0] red_next, green_next, blue_next;
  logic                   visible;

  always_comb begin
    hsync_next  = 1'b1;
    vsync_next  = 1'b1;
    red_next    = '0;
    green_next  = '0;
    blue_next   = '0;
    locked_next = (state_reg == LOCKED);
    visible     = (col < H_ACT) && (row < V_ACT);
    if (state_reg == LOCKED) begin
      hsync_next = ~((col >= H_START) && (col <= H_END));
      vsync_next = ~((row >= V_START) && (row <= V_END));
      if (visible) begin
        red_next   = red_d;
        green_next = green_d;
        blue_next  = blue_d;
      end
    end
  end

  logic                   hsync_reg, vsync_reg, locked_reg, err_reg;
  logic [VIDEO_WIDTH-1:0] red_reg, green_reg, blue_reg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hsync_reg  <= 1'b1;
      vsync_reg  <= 1'b1;
      red_reg    <= '0;
      green_reg  <= '0;
      blue_reg   <= '0;
      locked_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      hsync_reg  <= hsync_next;
      vsync_reg  <= vsync_next;
      red_reg    <= red_next;
      green_reg  <= green_next;
      blue_reg   <= blue_next;
      locked_reg <= locked_next;
      err_reg    <= err_pend_reg;
    end
  end

  assign o_hsync       = hsync_reg;
  assign o_vsync       = vsync_reg;
  assign o_red_video   = red_reg;
  assign o_green_video = green_reg;
  assign o_blue_video  = blue_reg;
  assign o_locked      = locked_reg;
  assign o_resync_err  = err_reg;

endmodule

// File: tb/tb_vga_sync_porch.sv
// Bench for vga_sync_porch on a scaled-down raster: fixed vector table plus a
// position-arithmetic reference model fed by a synthetic upstream source.
module tb_vga_sync_porch;

  localparam int VW  = 3;
  localparam int TC  = 40;
  localparam int TR  = 30;
  localparam int AC  = 24;
  localparam int AR  = 20;
  localparam int HFP = 4;
  localparam int HBP = 6;
  localparam int VFP = 3;
  localparam int VBP = 4;
  localparam int FRAME = TC * TR;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_hsync = 1'b0;
  logic          i_vsync = 1'b0;
  logic [VW-1:0] i_red_video = '0, i_green_video = '0, i_blue_video = '0;
  logic          o_hsync, o_vsync, o_locked, o_resync_err;
  logic [VW-1:0] o_red_video, o_green_video, o_blue_video;

  always #5 i_clk = ~i_clk;

  vga_sync_porch #(
    .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
    .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .H_FRONT_PORCH(HFP), .H_BACK_PORCH(HBP),
    .V_FRONT_PORCH(VFP), .V_BACK_PORCH(VBP)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_hsync(i_hsync), .i_vsync(i_vsync),
    .i_red_video(i_red_video), .i_green_video(i_green_video), .i_blue_video(i_blue_video),
    .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_red_video(o_red_video), .o_green_video(o_green_video), .o_blue_video(o_blue_video),
    .o_locked(o_locked), .o_resync_err(o_resync_err)
  );

  int    tests = 0;
  int    fails = 0;
  string cur_name = "init";

  // Reference model: position is simply pixels elapsed since the last frame start.
  logic          m_locked = 1'b0;
  logic          m_prev_v = 1'b0;
  logic          m_pend = 1'b0;
  int            m_n = 0;
  logic [VW-1:0] m_r = '0, m_g = '0, m_b = '0;

  int err_seen, hs_low_seen, vs_low_seen, lock_seen, red_seen;
  int gen_col = 0, gen_row = 0;

  task automatic check(input string name, input logic [3*VW+3:0] act, input logic [3*VW+3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 25)
        $display("FAIL %s t=%0t got hs/vs/r/g/b/lk/err=%b required %b", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic rst_v, input logic v, input logic h,
                      input logic [VW-1:0] r, input logic [VW-1:0] g, input logic [VW-1:0] b);
    logic          eh, ev, el, ee, fs_now;
    logic [VW-1:0] er, eg, eb;
    int            col, row;
    i_rst_n = rst_v; i_vsync = v; i_hsync = h;
    i_red_video = r; i_green_video = g; i_blue_video = b;
    eh = 1'b1; ev = 1'b1; er = '0; eg = '0; eb = '0; el = 1'b0; ee = 1'b0;
    if (!rst_v) begin
      m_locked = 1'b0; m_prev_v = 1'b0; m_pend = 1'b0; m_n = 0;
      m_r = '0; m_g = '0; m_b = '0;
    end else begin
      fs_now = v && !m_prev_v;
      if (m_locked) begin
        col = m_n % TC;
        row = (m_n / TC) % TR;
        eh = !(col >= AC + HFP && col < TC - HBP);
        ev = !(row >= AR + VFP && row < TR - VBP);
        if (col < AC && row < AR) begin er = m_r; eg = m_g; eb = m_b; end
      end
      el = m_locked;
      ee = m_pend;
      m_pend = fs_now && m_locked && ((m_n % FRAME) != FRAME - 1);
      if (fs_now) begin m_locked = 1'b1; m_n = 0; end
      else m_n++;
      m_prev_v = v; m_r = r; m_g = g; m_b = b;
    end
    @(posedge i_clk);
    #1;
    check(cur_name,
          {o_hsync, o_vsync, o_red_video, o_green_video, o_blue_video, o_locked, o_resync_err},
          {eh, ev, er, eg, eb, el, ee});
    if (o_resync_err) err_seen++;
    if (!o_hsync) hs_low_seen++;
    if (!o_vsync) vs_low_seen++;
    if (o_locked) lock_seen++;
    if (o_red_video == 3'd7) red_seen++;
  endtask

  // One upstream pixel; mode 0 random colours, mode 1 solid red.
  task automatic gen_step(input logic rst_v, input int mode);
    logic [VW-1:0] r, g, b;
    if (mode == 1) begin r = 3'd7; g = '0; b = '0; end
    else begin
      r = VW'($urandom_range(0, 7)); g = VW'($urandom_range(0, 7)); b = VW'($urandom_range(0, 7));
    end
    step(rst_v, gen_row < AR, gen_col < AC, r, g, b);
    if (gen_col == TC - 1) begin
      gen_col = 0;
      gen_row = (gen_row == TR - 1) ? 0 : gen_row + 1;
    end else gen_col++;
  endtask

  task automatic clear_stats();
    err_seen = 0; hs_low_seen = 0; vs_low_seen = 0; lock_seen = 0; red_seen = 0;
  endtask

  typedef struct {
    logic          rst_n, v, h;
    logic [VW-1:0] r;
    logic          ehs, evs;
    logic [VW-1:0] er;
    logic          el, ee;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // Reset, FS with i_hsync low, data through, reset, then FS on the first edge after release.
    tbl[0] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 3'd5, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 3'd6, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0};

    step(1'b0, 1'b0, 1'b0, '0, '0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0);
    cur_name = "table";
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rst_n, tbl[i].v, tbl[i].h, tbl[i].r, '0, '0);
      check($sformatf("table_vec%0d", i),
            {o_hsync, o_vsync, o_red_video, o_green_video, o_blue_video, o_locked, o_resync_err},
            {tbl[i].ehs, tbl[i].evs, tbl[i].er, 3'd0, 3'd0, tbl[i].el, tbl[i].ee});
    end
    $display("[TB] table vectors applied, failures so far %0d", fails);

    // Ideal source from two rows before frame end, two full frames.
    cur_name = "ideal";
    step(1'b0, 1'b0, 1'b0, '0, '0, '0);
    gen_col = 0; gen_row = TR - 2;
    for (int i = 0; i < 2 * TC; i++) gen_step(1'b1, 0);
    clear_stats();
    for (int i = 0; i < 2 * FRAME; i++) gen_step(1'b1, 0);
    check("ideal_hs_low", 32'(hs_low_seen), 32'(2 * TR * (TC - HBP - AC - HFP)));
    check("ideal_vs_low", 32'(vs_low_seen), 32'(2 * TC * (TR - VBP - AR - VFP)));
    check("ideal_no_err", 32'(err_seen), 32'd0);
    $display("[TB] ideal source: hs_low=%0d vs_low=%0d err=%0d", hs_low_seen, vs_low_seen, err_seen);

    // Solid red, one full frame.
    cur_name = "solid_red";
    clear_stats();
    for (int i = 0; i < FRAME; i++) gen_step(1'b1, 1);
    check("solid_red_count", 32'(red_seen), 32'(AC * AR));
    $display("[TB] solid red: visible red pixels=%0d", red_seen);

    // Reset during the vsync pulse row while the source keeps running.
    cur_name = "reset_vsync_row";
    while (!(gen_row == AR + VFP && gen_col == 5)) gen_step(1'b1, 0);
    for (int i = 0; i < 3; i++) gen_step(1'b0, 0);
    clear_stats();
    while (!(gen_row == TR - 1 && gen_col == TC - 1)) gen_step(1'b1, 0);
    check("reset_unlocked_until_fs", 32'(lock_seen + vs_low_seen + hs_low_seen), 32'd0);
    for (int i = 0; i < FRAME / 2; i++) gen_step(1'b1, 0);
    $display("[TB] reset mid-frame: relocked, failures so far %0d", fails);

    // Early frame start at col 9 of row 10, then one and a half frames from the new origin.
    cur_name = "early_fs";
    while (!(gen_row == 10 && gen_col == 9)) gen_step(1'b1, 0);
    clear_stats();
    step(1'b1, 1'b0, 1'b1, '0, '0, '0);
    gen_col = 0; gen_row = 0;
    for (int i = 0; i < FRAME + FRAME / 2; i++) gen_step(1'b1, 0);
    check("early_fs_single_pulse", 32'(err_seen), 32'd1);
    $display("[TB] early FS: resync pulses=%0d", err_seen);

    // i_vsync never rises: no lock, syncs idle.
    cur_name = "vsync_low";
    step(1'b0, 1'b0, 1'b0, '0, '0, '0);
    clear_stats();
    for (int i = 0; i < 2 * FRAME; i++)
      step(1'b1, 1'b0, (i % TC) < AC, VW'($urandom_range(0, 7)), VW'($urandom_range(0, 7)), 3'd1);
    check("vsync_low_no_lock", 32'(lock_seen + hs_low_seen + vs_low_seen + err_seen), 32'd0);
    $display("[TB] vsync held low: lock=%0d hs_low=%0d", lock_seen, hs_low_seen);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
